// File: rtl/mac_pkg.sv
// Shared types and helpers for the Booth multiply-accumulate unit.
// Pure definitions: no latency, no flow control.
package mac_pkg;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_SUB  = 2'b11
    } mode_e;

    localparam int SAT_MAXW = 128;

    function automatic bit op_width_ok(input int w);
        return (w >= 4) && (w <= 32) && ((w % 2) == 0);
    endfunction

    function automatic bit params_ok(input int a_w, input int b_w, input int acc_w,
                                     input int pipe, input int sat);
        return op_width_ok(a_w) && op_width_ok(b_w) &&
               (acc_w >= a_w + b_w + 1) && (acc_w <= SAT_MAXW) &&
               (pipe >= 1) && (pipe <= 4) && ((sat == 0) || (sat == 1));
    endfunction

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic [SAT_MAXW-1:0] sat_signed(input int width,
                                                       input logic signed [SAT_MAXW+1:0] value);
        logic signed [SAT_MAXW+1:0] hi;
        logic signed [SAT_MAXW+1:0] lo;
        hi = ((SAT_MAXW+2)'(1) <<< (width - 1)) - 1;
        lo = ~hi;
        if (value > hi) return hi[SAT_MAXW-1:0];
        if (value < lo) return lo[SAT_MAXW-1:0];
        return value[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/mac_booth_param_if.sv
// Operand/result handshake bundle for mac_booth_param.
// valid/ready on both the operand side and the result side.
interface mac_booth_param_if
    import mac_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int ACC_W = 48
);
    logic             i_valid;
    logic             o_ready;
    logic             i_multa_ns;
    logic             i_multb_ns;
    logic [A_W-1:0]   i_multa;
    logic [B_W-1:0]   i_multb;
    mode_e            i_mode;
    logic             o_valid;
    logic             i_ready;
    logic [ACC_W-1:0] o_result;
    logic             o_ovf;

    modport master (
        output i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb, i_mode, i_ready,
        input  o_ready, o_valid, o_result, o_ovf
    );

    modport slave (
        input  i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb, i_mode, i_ready,
        output o_ready, o_valid, o_result, o_ovf
    );
endinterface

// File: rtl/booth_mult_core.sv
// Exact A_W x B_W multiplier: radix-4 Booth partial products, 3:2 carry-save reduction, final add.
// Purely combinational; signedness of each operand chosen by its ns input.
module booth_mult_core #(
    parameter int A_W = 18,
    parameter int B_W = 18
) (
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    input  logic               a_ns_i,
    input  logic               b_ns_i,
    output logic [A_W+B_W-1:0] prod_o
);
    localparam int PW  = A_W + B_W;
    localparam int BXW = B_W + 2;
    localparam int ND  = BXW / 2;

    // The exact product always fits in PW bits, so all work is done modulo 2^PW.
    logic [A_W:0]  ax;
    logic [PW-1:0] m1;
    logic [PW-1:0] m2;
    logic [BXW:0]  bxe;

    assign ax  = {a_ns_i & a_i[A_W-1], a_i};
    assign m1  = {{(PW-A_W-1){ax[A_W]}}, ax};
    assign m2  = m1 << 1;
    assign bxe = {{2{b_ns_i & b_i[B_W-1]}}, b_i, 1'b0};

    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] pp;
    logic [PW-1:0] t;

    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < ND; i++) begin
            case (bxe[2*i +: 3])
                3'b001, 3'b010: pp = m1;
                3'b011:         pp = m2;
                3'b100:         pp = -m2;
                3'b101, 3'b110: pp = -m1;
                default:        pp = '0;
            endcase
            pp = pp << (2*i);
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        prod_o = s + c;
    end
endmodule

// File: rtl/mac_booth_param.sv
// Pipelined multiply-accumulate: operand stage, PIPE-1 product stages, accumulator/output stage.
// Latency PIPE+1, 1/cycle; a held result (o_valid & ~i_ready) freezes every stage and drops o_ready.
module mac_booth_param
    import mac_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int ACC_W = 48,
    parameter int PIPE  = 2,
    parameter int SAT   = 1
) (
    input logic          i_clk,
    input logic          i_rst,
    mac_booth_param_if.slave bus
);
    localparam int PW = A_W + B_W;
    localparam int XW = ACC_W + 2;

    generate
        if (!params_ok(A_W, B_W, ACC_W, PIPE, SAT)) begin : g_param_err
            $fatal(1, "mac_booth_param: illegal parameter combination");
        end
    endgenerate

    typedef struct packed {
        logic          vld;
        mode_e         mode;
        logic          sgn;
        logic [PW-1:0] prod;
    } pst_t;

    logic stall;
    logic o_valid_q;
    assign stall       = o_valid_q & ~bus.i_ready;
    assign bus.o_ready = ~stall;

    logic           v1_q;
    logic [A_W-1:0] a1_q;
    logic [B_W-1:0] b1_q;
    logic           sa1_q;
    logic           sb1_q;
    mode_e          mode1_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            sa1_q   <= 1'b0;
            sb1_q   <= 1'b0;
            mode1_q <= MODE_MUL;
        end else if (!stall) begin
            v1_q <= bus.i_valid;
            if (bus.i_valid) begin
                a1_q    <= bus.i_multa;
                b1_q    <= bus.i_multb;
                sa1_q   <= bus.i_multa_ns;
                sb1_q   <= bus.i_multb_ns;
                mode1_q <= bus.i_mode;
            end
        end
    end

    logic [PW-1:0] prod1;
    pst_t          p1;
    pst_t          fin;

    booth_mult_core #(.A_W(A_W), .B_W(B_W)) u_core (
        .a_i    (a1_q),
        .b_i    (b1_q),
        .a_ns_i (sa1_q),
        .b_ns_i (sb1_q),
        .prod_o (prod1)
    );

    assign p1 = '{vld: v1_q, mode: mode1_q, sgn: sa1_q | sb1_q, prod: prod1};

    generate
        if (PIPE == 1) begin : g_nopipe
            assign fin = p1;
        end else begin : g_pipe
            pst_t pq_q [PIPE-1];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < PIPE-1; i++) pq_q[i] <= '0;
                end else if (!stall) begin
                    pq_q[0] <= p1;
                    for (int i = 1; i < PIPE-1; i++) pq_q[i] <= pq_q[i-1];
                end
            end
            assign fin = pq_q[PIPE-2];
        end
    endgenerate

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] res_q;
    logic [ACC_W-1:0] res_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [XW-1:0]    prod_x;
    logic [XW-1:0]    acc_x;
    logic [XW-1:0]    sum;

    // Two guard bits make the ACC/SUB sum exact, so overflow is just the top three bits disagreeing.
    always_comb begin
        prod_x = fin.sgn ? {{(XW-PW){fin.prod[PW-1]}}, fin.prod} : {{(XW-PW){1'b0}}, fin.prod};
        acc_x  = {{2{acc_q[ACC_W-1]}}, acc_q};
        case (fin.mode)
            MODE_ACC: sum = acc_x + prod_x;
            MODE_SUB: sum = acc_x - prod_x;
            default:  sum = prod_x;
        endcase
        ovf_d = (sum[XW-1:ACC_W-1] != '0) && (sum[XW-1:ACC_W-1] != '1);
        if (ovf_d && (SAT != 0)) res_d = ACC_W'(sat_signed(ACC_W, (SAT_MAXW+2)'(signed'(sum))));
        else                     res_d = sum[ACC_W-1:0];
        acc_d = (fin.mode == MODE_MUL) ? acc_q : res_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
        end else if (!stall) begin
            o_valid_q <= fin.vld;
            if (fin.vld) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
                acc_q <= acc_d;
            end
        end
    end

    assign bus.o_valid  = o_valid_q;
    assign bus.o_result = res_q;
    assign bus.o_ovf    = ovf_q;
endmodule
